// File: rtl/easy_axis_upsizer.sv
// easy_axis_upsizer
//   Packs RATIO consecutive DWIDTH-bit AXI-Stream words into one wide beat.
//   Lane 0 occupies the least-significant word. A beat is emitted when the
//   last lane fills or when the input word carries tlast. In a partial beat
//   the unused lanes have keep=0 and zero data.
//   Storage is one accumulation register and one output register. The input
//   can therefore keep streaming while the output beat waits for downstream.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   s_axis_*          narrow input stream (tdata, tvalid, tlast, tready)
//   m_axis_*          wide output stream (tdata, tkeep, tvalid, tlast, tready)
//   lane_idx          debug: index of the next lane to be filled
module easy_axis_upsizer #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned RATIO  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DWIDTH-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DWIDTH*RATIO-1:0]    m_axis_tdata,
  output logic [RATIO-1:0]           m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(RATIO)-1:0]   lane_idx
);

  localparam int unsigned LW = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [DWIDTH*RATIO-1:0] acc_data_q, acc_data_d;
  logic [RATIO-1:0]        acc_keep_q, acc_keep_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [DWIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]        out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic                    completes;
  logic                    out_free;
  logic                    s_ready;
  logic                    accept;
  logic [DWIDTH*RATIO-1:0] merged_data;
  logic [RATIO-1:0]        merged_keep;

  always_comb begin
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    lane_d      = lane_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    completes = (lane_q == LAST_LANE) || s_axis_tlast;
    out_free  = !out_valid_q || m_axis_tready;
    // A non-completing word only touches the accumulator, so it never
    // waits on the output side.
    s_ready   = rst_n && (!completes || out_free);
    accept    = s_axis_tvalid && s_ready;

    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (lane_q == LW'(i)) begin
        merged_data[i*DWIDTH +: DWIDTH] = s_axis_tdata;
        merged_keep[i]                  = 1'b1;
      end
    end

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (completes) begin
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = s_axis_tlast;
        out_valid_d = 1'b1;
        // Clearing the accumulator data too keeps unused lanes of the next
        // partial beat at zero.
        acc_data_d  = '0;
        acc_keep_d  = '0;
        lane_d      = '0;
      end else begin
        acc_data_d  = merged_data;
        acc_keep_d  = merged_keep;
        lane_d      = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      lane_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      lane_q      <= lane_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign lane_idx      = lane_q;

endmodule

// File: tb/tb_easy_axis_upsizer.sv
module tb_easy_axis_upsizer;

  localparam int unsigned DW = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned BW = DW * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [BW-1:0] m_data;
  logic [R-1:0]  m_keep;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [1:0]    lane_idx;

  always #5 clk = ~clk;

  easy_axis_upsizer #(.DWIDTH(DW), .RATIO(R)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .lane_idx      (lane_idx)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned stalls      = 0;
  int          cyc         = 0;

  // Reference model: words of the open packet, expected and observed beats
  // as {data, keep, last}.
  logic [DW-1:0]     pkt_q [$];
  logic [BW+R:0]     exp_q [$];
  logic [BW+R:0]     got_q [$];
  int                beat_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [BW-1:0] bd;
    logic [R-1:0]  bk;
    if (!rst_n) begin
      pkt_q.delete();
      exp_q.delete();
    end else begin
      if (s_valid && s_ready) begin
        pkt_q.push_back(s_data);
        if (pkt_q.size() == R || s_last) begin
          bd = '0;
          bk = '0;
          foreach (pkt_q[j]) begin
            bd[j*DW +: DW] = pkt_q[j];
            bk[j]          = 1'b1;
          end
          exp_q.push_back({bd, bk, s_last});
          pkt_q.delete();
        end
      end
      if (m_valid && m_ready) begin
        got_q.push_back({m_data, m_keep, m_last});
        beat_cyc.push_back(cyc);
      end
    end
  end

  function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
      stalls++;
    end
    if (!s_ready) chk("send_timeout", 160'(s_ready), 160'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    int unsigned n = 0;
    m_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk({tag, "_beat_count"}, 160'(got_q.size()), 160'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_beat"}, 160'(got_q.pop_front()), 160'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct packed {
    logic [2:0]         n;
    logic [3:0][DW-1:0] w;
    logic               last;
    logic [BW-1:0]      exp_data;
    logic [R-1:0]       exp_keep;
    logic               exp_last;
  } vec_t;

  localparam logic [BW-1:0] BP_BEAT0 = 128'h00000103_00000102_00000101_00000100;

  initial begin
    vec_t vt [5];
    int unsigned acc;
    int unsigned bad;
    int unsigned i;

    vt[0] = '{3'd4, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1,
              128'h00000044_00000033_00000022_00000011, 4'b1111, 1'b1};
    vt[1] = '{3'd2, {32'h0, 32'h0, 32'hA2, 32'hA1}, 1'b1,
              128'h00000000_00000000_000000A2_000000A1, 4'b0011, 1'b1};
    vt[2] = '{3'd1, {32'h0, 32'h0, 32'h0, 32'h55}, 1'b1,
              128'h00000000_00000000_00000000_00000055, 4'b0001, 1'b1};
    vt[3] = '{3'd3, {32'h0, 32'hC3, 32'hC2, 32'hC1}, 1'b1,
              128'h00000000_000000C3_000000C2_000000C1, 4'b0111, 1'b1};
    vt[4] = '{3'd4, {32'hFEEDF00D, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF}, 1'b0,
              128'hFEEDF00D_12345678_CAFEBABE_DEADBEEF, 4'b1111, 1'b0};

    // Reset state
    rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h99; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 160'(s_ready), 160'(0));
    chk("rst_m_valid", 160'(m_valid), 160'(0));
    chk("rst_m_last",  160'(m_last),  160'(0));
    chk("rst_m_keep",  160'(m_keep),  160'(0));
    chk("rst_m_data",  160'(m_data),  160'(0));
    chk("rst_lane",    160'(lane_idx), 160'(0));
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rst_release_ready", 160'(s_ready), 160'(1));
    @(posedge clk); #1;

    // Table vectors
    m_ready = 1'b1;
    foreach (vt[v]) begin
      for (int unsigned k = 0; k < vt[v].n; k++) begin
        send(vt[v].w[k], (k == vt[v].n - 1) ? vt[v].last : 1'b0);
      end
      chk("vec_valid", 160'(m_valid),  160'(1));
      chk("vec_data",  160'(m_data),   160'(vt[v].exp_data));
      chk("vec_keep",  160'(m_keep),   160'(vt[v].exp_keep));
      chk("vec_last",  160'(m_last),   160'(vt[v].exp_last));
      chk("vec_lane",  160'(lane_idx), 160'(0));
      @(posedge clk); #1;
    end
    drain_check("table");

    // Backpressure: 12 words offered against a stalled output
    m_ready = 1'b0;
    i = 0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      s_valid = 1'b1; s_data = 32'h100 + i; s_last = 1'b0;
      #1;
      if (c >= 5 && (m_valid !== 1'b1 || m_data !== BP_BEAT0 || m_keep !== 4'b1111)) bad++;
      if (s_ready) i++;
      @(posedge clk); #1;
    end
    #1;
    chk("bp_accepted", 160'(i), 160'(7));
    chk("bp_ready_8th", 160'(s_ready), 160'(0));
    chk("bp_stable", 160'(bad), 160'(0));
    chk("bp_lane", 160'(lane_idx), 160'(3));
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (i < 12) begin
      send(32'h100 + i, 1'b0);
      i++;
    end
    drain_check("backpressure");

    // Throughput: 64 words, 16 beats, 4 cycles apart
    beat_cyc.delete();
    stalls = 0;
    for (int unsigned w = 0; w < 64; w++) send(32'h2000 + w, (w % 16) == 15);
    @(posedge clk); #1;
    chk("tp_stalls", 160'(stalls), 160'(0));
    chk("tp_beats", 160'(beat_cyc.size()), 160'(16));
    bad = 0;
    for (int j = 1; j < beat_cyc.size(); j++) if (beat_cyc[j] - beat_cyc[j-1] != 4) bad++;
    chk("tp_spacing", 160'(bad), 160'(0));
    drain_check("throughput");

    // Reset mid-packet
    send(32'h01, 1'b0);
    send(32'h02, 1'b0);
    rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h77;
    #1;
    chk("midrst_ready", 160'(s_ready), 160'(0));
    @(posedge clk); #1;
    chk("midrst_lane", 160'(lane_idx), 160'(0));
    chk("midrst_valid", 160'(m_valid), 160'(0));
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("midrst_release_ready", 160'(s_ready), 160'(1));
    for (int unsigned w = 3; w <= 6; w++) send(32'(w), w == 6);
    chk("midrst_data", 160'(m_data), 160'(128'h00000006_00000005_00000004_00000003));
    chk("midrst_keep", 160'(m_keep), 160'(4'b1111));
    drain_check("midreset");

    // Idle gap never flushes a partial beat
    send(32'h10, 1'b0);
    chk("gap_lane", 160'(lane_idx), 160'(1));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("gap_no_beat", 160'(bad + got_q.size()), 160'(0));
    send(32'h20, 1'b1);
    chk("gap_data", 160'(m_data), 160'(128'h00000000_00000000_00000020_00000010));
    chk("gap_keep", 160'(m_keep), 160'(4'b0011));
    chk("gap_last", 160'(m_last), 160'(1));
    drain_check("gap");

    // Random traffic against the packing model
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(3) != 0);
      s_valid = ($urandom_range(9) < 7);
      s_data  = $urandom;
      s_last  = ($urandom_range(4) == 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    drain_check("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
